// File: rtl/sequence_detector_1011.sv
// -----------------------------------------------------------------------------
// sequence_detector_1011
//
// Serial detector for the bit pattern 1011 (first bit first, overlapping
// matches allowed). Two independent machines watch the same input:
//   - a 4-state Mealy machine whose flag rises while the final 1 is on `in`;
//   - a 5-state Moore machine whose flag rises for one cycle after the edge
//     that samples the final 1.
// Each machine feeds a saturating match counter.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous, active-high reset (FSMs to idle, counters to 0)
//   in             serial data bit, sampled on every rising edge
//   mealy_detected Mealy flag: f(state, in), forced low while rst is high
//   moore_detected Moore flag: f(registered state) only
//   mealy_count    saturating count of Mealy detections
//   moore_count    saturating count of Moore detections
// -----------------------------------------------------------------------------
module sequence_detector_1011 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             mealy_detected,
    output logic             moore_detected,
    output logic [CNT_W-1:0] mealy_count,
    output logic [CNT_W-1:0] moore_count
);

    typedef enum logic [1:0] {
        MEALY_A = 2'd0,   // idle
        MEALY_B = 2'd1,   // seen "1"
        MEALY_C = 2'd2,   // seen "10"
        MEALY_D = 2'd3    // seen "101"
    } mealy_state_t;

    typedef enum logic [2:0] {
        MOORE_M0    = 3'd0,   // idle
        MOORE_M1    = 3'd1,
        MOORE_M10   = 3'd2,
        MOORE_M101  = 3'd3,
        MOORE_M1011 = 3'd4    // match, flag high for this cycle
    } moore_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mealy_state_t mealy_state_r;
    mealy_state_t mealy_next_s;
    moore_state_t moore_state_r;
    moore_state_t moore_next_s;

    // Mealy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mealy_state_r <= MEALY_A;
        end else begin
            mealy_state_r <= mealy_next_s;
        end
    end

    // Mealy next-state and detect flag; the flag is masked by rst so a
    // reset edge never counts as a match.
    always_comb begin
        mealy_next_s   = MEALY_A;
        mealy_detected = 1'b0;
        case (mealy_state_r)
            MEALY_A: mealy_next_s = in ? MEALY_B : MEALY_A;
            MEALY_B: mealy_next_s = in ? MEALY_B : MEALY_C;
            MEALY_C: mealy_next_s = in ? MEALY_D : MEALY_A;
            MEALY_D: begin
                // Trailing 1 of a match is the leading 1 of the next one.
                mealy_next_s   = in ? MEALY_B : MEALY_C;
                mealy_detected = in & ~rst;
            end
            default: mealy_next_s = MEALY_A;
        endcase
    end

    // Moore state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            moore_state_r <= MOORE_M0;
        end else begin
            moore_state_r <= moore_next_s;
        end
    end

    // Moore next-state and detect flag; unused encodings fall back to idle.
    always_comb begin
        moore_next_s   = MOORE_M0;
        moore_detected = 1'b0;
        case (moore_state_r)
            MOORE_M0:    moore_next_s = in ? MOORE_M1    : MOORE_M0;
            MOORE_M1:    moore_next_s = in ? MOORE_M1    : MOORE_M10;
            MOORE_M10:   moore_next_s = in ? MOORE_M101  : MOORE_M0;
            MOORE_M101:  moore_next_s = in ? MOORE_M1011 : MOORE_M10;
            MOORE_M1011: begin
                moore_next_s   = in ? MOORE_M1 : MOORE_M10;
                moore_detected = 1'b1;
            end
            default:     moore_next_s = MOORE_M0;
        endcase
    end

    // Mealy match counter, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            mealy_count <= CNT_ZERO;
        end else if (mealy_detected && (mealy_count != CNT_MAX)) begin
            mealy_count <= mealy_count + CNT_ONE;
        end else begin
            mealy_count <= mealy_count;
        end
    end

    // Moore match counter, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            moore_count <= CNT_ZERO;
        end else if (moore_detected && (moore_count != CNT_MAX)) begin
            moore_count <= moore_count + CNT_ONE;
        end else begin
            moore_count <= moore_count;
        end
    end

endmodule

// File: tb/tb_sequence_detector_1011.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector_1011
//
// Self-checking bench. Two instances share clk/rst/in: the default 8-bit
// counter build and a 2-bit counter build for saturation. The reference model
// keeps the last four bits sampled since reset and simple match counts;
// expected outputs are derived from the "last bits equal 1011" rule.
// -----------------------------------------------------------------------------
module tb_sequence_detector_1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in  = 1'b0;
    logic       mealy_detected;
    logic       moore_detected;
    logic [7:0] mealy_count;
    logic [7:0] moore_count;
    logic       s_mealy_detected;
    logic       s_moore_detected;
    logic [1:0] s_mealy_count;
    logic [1:0] s_moore_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit hist[$];
    int m_cnt = 0;
    int o_cnt = 0;

    always #5 clk = ~clk;

    sequence_detector_1011 #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in(in),
        .mealy_detected(mealy_detected), .moore_detected(moore_detected),
        .mealy_count(mealy_count), .moore_count(moore_count)
    );

    sequence_detector_1011 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in(in),
        .mealy_detected(s_mealy_detected), .moore_detected(s_moore_detected),
        .mealy_count(s_mealy_count), .moore_count(s_moore_count)
    );

    // Mealy: the three bits already sampled plus the bit now on `in` spell 1011.
    function automatic bit exp_mealy(input bit b, input bit r);
        int n;
        n = hist.size();
        if (r || n < 3) return 1'b0;
        return (hist[n-3] == 1'b1) && (hist[n-2] == 1'b0) && (hist[n-1] == 1'b1) && b;
    endfunction

    // Moore: the last four sampled bits spell 1011.
    function automatic bit exp_moore();
        if (hist.size() < 4) return 1'b0;
        return (hist[0] == 1'b1) && (hist[1] == 1'b0) && (hist[2] == 1'b1) && (hist[3] == 1'b1);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [23:0] exp_status(input bit b, input bit r);
        bit me;
        bit mo;
        me = exp_mealy(b, r);
        mo = exp_moore();
        return {me, mo, 8'(sat(m_cnt, 255)), 8'(sat(o_cnt, 255)),
                2'(sat(m_cnt, 3)), 2'(sat(o_cnt, 3)), me, mo};
    endfunction

    function automatic logic [23:0] obs_status();
        return {mealy_detected, moore_detected, mealy_count, moore_count,
                s_mealy_count, s_moore_count, s_mealy_detected, s_moore_detected};
    endfunction

    // Apply one input bit (and rst) just after a rising edge; return at the
    // following falling edge where outputs are sampled.
    task automatic drive(input bit b, input bit r);
        in  = b;
        rst = r;
        @(negedge clk);
    endtask

    // Clock the applied bit in and advance the model.
    task automatic advance();
        bit em;
        bit eo;
        em = exp_mealy(in, rst);
        eo = exp_moore();
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            m_cnt = 0;
            o_cnt = 0;
        end else begin
            if (em) m_cnt++;
            if (eo) o_cnt++;
            hist.push_back(in);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1);
        total++;
        if (obs_status() !== exp_status(1'b1, 1'b1)) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", obs_status(), exp_status(1'b1, 1'b1));
        end
        advance();
        drive(1'b0, 1'b0);
        total++;
        if ({moore_detected, mealy_count, moore_count} !== 17'd0) begin
            bad++;
            $display("FAIL reset_state: got %b want 0", {moore_detected, mealy_count, moore_count});
        end
        advance();
    endtask

    task automatic test_single_match();
        logic [8:0] s;
        s = 9'b101101011;
        do_reset();
        for (int i = 8; i >= 0; i--) begin
            drive(s[i], 1'b0);
            total++;
            if (obs_status() !== exp_status(s[i], 1'b0)) begin
                bad++;
                $display("FAIL single_match bit %0d: got %b want %b", 9 - i, obs_status(), exp_status(s[i], 1'b0));
            end
            if (i == 5) begin
                total++;
                if (mealy_detected !== 1'b1) begin
                    bad++;
                    $display("FAIL single_match_bit4: got %b want 1", mealy_detected);
                end
            end
            advance();
        end
        drive(1'b0, 1'b0);
        total++;
        if (moore_detected !== 1'b1) begin
            bad++;
            $display("FAIL single_match_moore_lag: got %b want 1", moore_detected);
        end
        advance();
        drive(1'b0, 1'b0);
        total++;
        if ({mealy_count, moore_count} !== {8'd2, 8'd2}) begin
            bad++;
            $display("FAIL single_match_counts: got %0d/%0d want 2/2", mealy_count, moore_count);
        end
        advance();
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1011011;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(s[i], 1'b0);
            total++;
            if (obs_status() !== exp_status(s[i], 1'b0)) begin
                bad++;
                $display("FAIL overlap bit %0d: got %b want %b", 7 - i, obs_status(), exp_status(s[i], 1'b0));
            end
            advance();
        end
        drive(1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0);
        total++;
        if ({mealy_count, moore_count} !== {8'd2, 8'd2}) begin
            bad++;
            $display("FAIL overlap_counts: got %0d/%0d want 2/2", mealy_count, moore_count);
        end
        advance();
    endtask

    task automatic test_near_miss();
        logic [3:0] pats [4];
        int         lens [4];
        pats = '{4'b1010, 4'b1001, 4'b0111, 4'b0000};
        lens = '{4, 4, 3, 4};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = lens[k] - 1; i >= 0; i--) begin
                drive(pats[k][i], 1'b0);
                total++;
                if (obs_status() !== exp_status(pats[k][i], 1'b0)) begin
                    bad++;
                    $display("FAIL near_miss p%0d bit %0d: got %b want %b", k, lens[k] - i, obs_status(), exp_status(pats[k][i], 1'b0));
                end
                advance();
            end
            drive(1'b0, 1'b0);
            total++;
            if ({moore_detected, mealy_count, moore_count} !== 17'd0) begin
                bad++;
                $display("FAIL near_miss_counts p%0d: got %b want 0", k, {moore_detected, mealy_count, moore_count});
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic [7:0] r;
        s = 8'b10111011;   // 1,0,1,(1 on reset edge),1,0,1,1
        r = 8'b00010000;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            drive(s[i], r[i]);
            total++;
            if (obs_status() !== exp_status(s[i], r[i])) begin
                bad++;
                $display("FAIL reset_mid step %0d: got %b want %b", 8 - i, obs_status(), exp_status(s[i], r[i]));
            end
            if (i == 4 || i == 0) begin
                total++;
                if (mealy_detected !== (i == 0)) begin
                    bad++;
                    $display("FAIL reset_mid_flag step %0d: got %b want %b", 8 - i, mealy_detected, (i == 0));
                end
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        logic [3:0] p;
        p = 4'b1011;
        do_reset();
        for (int m = 0; m < 6; m++) begin
            for (int i = 3; i >= 0; i--) begin
                drive(p[i], 1'b0);
                total++;
                if (obs_status() !== exp_status(p[i], 1'b0)) begin
                    bad++;
                    $display("FAIL saturation m%0d bit %0d: got %b want %b", m, 4 - i, obs_status(), exp_status(p[i], 1'b0));
                end
                advance();
            end
        end
        drive(1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0);
        total++;
        if ({s_mealy_count, s_moore_count, mealy_count, moore_count} !== {2'd3, 2'd3, 8'd6, 8'd6}) begin
            bad++;
            $display("FAIL saturation_hold: got %0d/%0d %0d/%0d want 3/3 6/6",
                     s_mealy_count, s_moore_count, mealy_count, moore_count);
        end
        advance();
    endtask

    task automatic test_random();
        bit b;
        bit r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 59) == 0);
            drive(b, r);
            total++;
            if (obs_status() !== exp_status(b, r)) begin
                bad++;
                $display("FAIL random cycle %0d: got %b want %b", i, obs_status(), exp_status(b, r));
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_match();
        test_overlap();
        test_near_miss();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
